// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//   Pipelined carry-lookahead adder/subtractor. One BLOCK-bit lookahead
//   slice is resolved per stage, so a WIDTH-bit operation takes
//   NSTG = WIDTH/BLOCK stages at one operation per cycle.
//
// Parameters
//   WIDTH  operand/result width, a multiple of BLOCK
//   BLOCK  bits per lookahead slice, 1..8
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (combinational from out_valid/out_ready)
//   a, b       operands
//   cin        carry-in (add) or borrow-in (sub)
//   sub        0 = a+b+cin, 1 = a-b-cin
//   out_valid  result beat valid
//   out_ready  consumer accepts the result
//   sum        result, modulo 2^WIDTH
//   cout       carry out of the MSB (sub: 1 = no borrow)
//   ovf        signed overflow
//   zero       sum == 0
module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NSTG = WIDTH / BLOCK;

    if (BLOCK < 1 || BLOCK > 8 || WIDTH < BLOCK || (WIDTH % BLOCK) != 0) begin : g_bad_param
        $error("cla_pipe_adder: WIDTH must be a non-zero multiple of BLOCK, BLOCK in 1..8");
    end

    // Flattened lookahead: carry i is the OR of every generate term j<i
    // propagated through bits j+1..i-1, plus the block carry-in propagated
    // through bits 0..i-1. The loops only enumerate product terms; no carry
    // term depends on another computed carry.
    function automatic logic [BLOCK:0] cla_carries(input logic [BLOCK-1:0] p,
                                                   input logic [BLOCK-1:0] g,
                                                   input logic             ci);
        logic [BLOCK:0] c;
        logic           t;
        for (int i = 0; i <= BLOCK; i++) begin
            t = ci;
            for (int m = 0; m < i; m++) t = t & p[m];
            c[i] = t;
            for (int j = 0; j < i; j++) begin
                t = g[j];
                for (int m = j + 1; m < i; m++) t = t & p[m];
                c[i] = c[i] | t;
            end
        end
        return c;
    endfunction

    logic en;
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Stage registers. Operands are kept shifted so the slice a stage works
    // on is always in the low BLOCK bits.
    logic             vld_p [NSTG];
    logic [WIDTH-1:0] a_p   [NSTG];
    logic [WIDTH-1:0] b_p   [NSTG];
    logic [WIDTH-1:0] sum_p [NSTG];
    logic             c_p   [NSTG];
    logic             ovf_p;
    logic             zero_p;

    logic             vld_n [NSTG];
    logic [WIDTH-1:0] a_n   [NSTG];
    logic [WIDTH-1:0] b_n   [NSTG];
    logic [WIDTH-1:0] sum_n [NSTG];
    logic             c_n   [NSTG];
    logic             ovf_n;
    logic             zero_n;

    for (genvar k = 0; k < NSTG; k++) begin : g_stg
        logic             vi;
        logic [WIDTH-1:0] ai;
        logic [WIDTH-1:0] bi;
        logic [WIDTH-1:0] si;
        logic             ci;
        logic [BLOCK-1:0] p;
        logic [BLOCK-1:0] g;
        logic [BLOCK:0]   c;
        logic [WIDTH-1:0] s_w;

        if (k == 0) begin : g_in
            // ---- stage 0: operand conditioning at accept ----
            assign vi = in_valid;
            assign ai = a;
            assign bi = sub ? ~b : b;
            assign ci = sub ? ~cin : cin;
            assign si = '0;
        end else begin : g_chain
            // ---- stage k: fed from stage k-1 registers ----
            assign vi = vld_p[k-1];
            assign ai = a_p[k-1];
            assign bi = b_p[k-1];
            assign ci = c_p[k-1];
            assign si = sum_p[k-1];
        end

        assign p   = ai[BLOCK-1:0] ^ bi[BLOCK-1:0];
        assign g   = ai[BLOCK-1:0] & bi[BLOCK-1:0];
        assign c   = cla_carries(p, g, ci);
        assign s_w = WIDTH'(p ^ c[BLOCK-1:0]) << (k * BLOCK);

        assign vld_n[k] = vi;
        assign a_n[k]   = ai >> BLOCK;
        assign b_n[k]   = bi >> BLOCK;
        assign sum_n[k] = si | s_w;
        assign c_n[k]   = c[BLOCK];

        if (k == NSTG - 1) begin : g_flags
            // Overflow: carry into the MSB differs from carry out of it.
            assign ovf_n  = c[BLOCK] ^ c[BLOCK-1];
            assign zero_n = ((si | s_w) == '0);
        end
    end

    // ---- pipeline register bank: all stages advance together on en ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_p[k] <= 1'b0;
                a_p[k]   <= '0;
                b_p[k]   <= '0;
                sum_p[k] <= '0;
                c_p[k]   <= 1'b0;
            end
            ovf_p  <= 1'b0;
            zero_p <= 1'b0;
        end else if (en) begin
            for (int k = 0; k < NSTG; k++) begin
                vld_p[k] <= vld_n[k];
                a_p[k]   <= a_n[k];
                b_p[k]   <= b_n[k];
                sum_p[k] <= sum_n[k];
                c_p[k]   <= c_n[k];
            end
            ovf_p  <= ovf_n;
            zero_p <= zero_n;
        end
    end

    assign out_valid = vld_p[NSTG-1];
    assign sum       = sum_p[NSTG-1];
    assign cout      = c_p[NSTG-1];
    assign ovf       = ovf_p;
    assign zero      = zero_p;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Testbench for cla_pipe_adder: four configurations run concurrently, each
// with its own driver, scoreboard queue and monitor.
module tb_cla_pipe_adder;

    localparam int NCFG = 4;
    localparam int NRAND = 10000;

    function automatic int cfg_w(input int i);
        case (i)
            0:       return 16;
            1:       return 8;
            2:       return 32;
            default: return 12;
        endcase
    endfunction

    function automatic int cfg_b(input int i);
        case (i)
            0:       return 4;
            1:       return 8;
            2:       return 4;
            default: return 3;
        endcase
    endfunction

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int errors   = 0;
    int done_cnt = 0;

    task automatic chk(input string nm, input int cfg, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL cfg%0d %s: got %0h, want %0h", cfg, nm, act, req);
        end
    endtask

    for (genvar gi = 0; gi < NCFG; gi++) begin : g_cfg
        localparam int W = cfg_w(gi);
        localparam int B = cfg_b(gi);
        localparam int N = W / B;

        logic         rst;
        logic         in_valid;
        logic         in_ready;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic         out_valid;
        logic         out_ready;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;

        logic [W+2:0] exp_q[$];
        int           acc_q[$];
        int           cyc = 0;
        bit           lat_chk = 1'b1;

        cla_pipe_adder #(.WIDTH(W), .BLOCK(B)) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid),
            .in_ready (in_ready),
            .a        (a),
            .b        (b),
            .cin      (cin),
            .sub      (sub),
            .out_valid(out_valid),
            .out_ready(out_ready),
            .sum      (sum),
            .cout     (cout),
            .ovf      (ovf),
            .zero     (zero)
        );

        always @(posedge clk) cyc <= cyc + 1;

        // Reference: plain integer arithmetic on unsigned and signed views.
        function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                               input logic ci, input logic s);
            longint       ux, uy, sx, sy, c, full, sres, smax, smin;
            logic         co, ov;
            logic [W-1:0] r;
            ux   = longint'(x);
            uy   = longint'(y);
            sx   = longint'($signed(x));
            sy   = longint'($signed(y));
            c    = longint'(ci);
            smax = (longint'(1) << (W - 1)) - 1;
            smin = -(longint'(1) << (W - 1));
            if (!s) begin
                full = ux + uy + c;
                co   = (full >>> W) != 0;
                sres = sx + sy + c;
            end else begin
                full = ux - uy - c;
                co   = (ux >= uy + c);
                sres = sx - sy - c;
            end
            ov = (sres > smax) || (sres < smin);
            r  = full[W-1:0];
            return {r, co, ov, (r == '0)};
        endfunction

        task automatic drive(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic ci, input logic s, input logic ordy, output bit took);
            in_valid  = v;
            a         = x;
            b         = y;
            cin       = ci;
            sub       = s;
            out_ready = ordy;
            @(negedge clk);
            took = v && in_ready && !rst;
            if (took) begin
                exp_q.push_back(model(x, y, ci, s));
                acc_q.push_back(cyc);
            end
            @(posedge clk);
            #1;
        endtask

        task automatic idle(input logic ordy);
            bit t;
            drive(1'b0, '0, '0, 1'b0, 1'b0, ordy, t);
        endtask

        // Monitor: pops and compares on every output handshake, checks
        // stall behaviour and the ready rule.
        initial begin : mon
            bit           prev_stall;
            logic [W+2:0] prev_out;
            logic [W+2:0] cur;
            logic [W+2:0] e;
            int           acc;
            prev_stall = 1'b0;
            prev_out   = '0;
            forever begin
                @(negedge clk);
                if (rst) begin
                    prev_stall = 1'b0;
                    continue;
                end
                cur = {sum, cout, ovf, zero};
                if (prev_stall) begin
                    chk("stall_hold_valid", gi, out_valid, 1);
                    chk("stall_hold_data", gi, cur, prev_out);
                end
                chk("in_ready", gi, in_ready, !(out_valid && !out_ready));
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL cfg%0d unexpected_output: got sum %0h, want no output", gi, sum);
                    end else begin
                        e   = exp_q.pop_front();
                        acc = acc_q.pop_front();
                        chk("result", gi, cur, e);
                        if (lat_chk) chk("latency", gi, cyc - acc, N);
                    end
                end
                prev_stall = out_valid && !out_ready;
                prev_out   = cur;
            end
        end

        initial begin : drv
            bit           t;
            int           nacc;
            logic [W-1:0] ones;
            logic [W-1:0] msb;
            ones      = '1;
            msb       = '0;
            msb[W-1]  = 1'b1;
            rst       = 1'b1;
            in_valid  = 1'b0;
            a         = '0;
            b         = '0;
            cin       = 1'b0;
            sub       = 1'b0;
            out_ready = 1'b1;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            #1;
            chk("rst_out_valid", gi, out_valid, 0);
            chk("rst_sum", gi, sum, 0);
            chk("rst_cout", gi, cout, 0);
            chk("rst_ovf", gi, ovf, 0);
            chk("rst_zero", gi, zero, 0);
            chk("rst_in_ready", gi, in_ready, 1);
            @(posedge clk);
            #1;

            // Boundary vectors and an 8-beat stream, no stalls.
            lat_chk = 1'b1;
            drive(1'b1, ones, W'(1), 1'b0, 1'b0, 1'b1, t);
            drive(1'b1, ones >> 1, W'(1), 1'b0, 1'b0, 1'b1, t);
            drive(1'b1, W'(5), W'(7), 1'b0, 1'b1, 1'b1, t);
            drive(1'b1, msb, W'(1), 1'b0, 1'b1, 1'b1, t);
            drive(1'b1, W'(5), W'(5), 1'b1, 1'b1, 1'b1, t);
            drive(1'b1, ones, ones, 1'b1, 1'b0, 1'b1, t);
            drive(1'b1, msb, msb, 1'b0, 1'b0, 1'b1, t);
            for (int i = 0; i < 8; i++)
                drive(1'b1, W'(i), W'(i) << (W - 4), 1'b0, 1'b0, 1'b1, t);
            repeat (N + 2) idle(1'b1);
            chk("stream_drain", gi, exp_q.size(), 0);

            // Backpressure: fill, then hold the consumer off for 5 cycles.
            lat_chk = 1'b0;
            for (int i = 0; i < N; i++)
                drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, t);
            chk("bp_full", gi, out_valid, 1);
            repeat (5) begin
                drive(1'b1, W'($urandom), W'($urandom), 1'b0, 1'b0, 1'b0, t);
                chk("bp_in_ready", gi, in_ready, 0);
                chk("bp_no_accept", gi, t, 0);
            end
            repeat (N + 3) idle(1'b1);
            chk("bp_drain", gi, exp_q.size(), 0);

            // Reset with beats in flight: nothing may emerge afterwards.
            lat_chk = 1'b1;
            for (int i = 0; i < 3; i++)
                drive(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 1'b1, t);
            repeat (N) idle(1'b0);
            chk("rf_busy", gi, out_valid, 1);
            rst = 1'b1;
            #1;
            chk("rf_async_drop", gi, out_valid, 0);
            exp_q.delete();
            acc_q.delete();
            @(posedge clk);
            #1 rst = 1'b0;
            repeat (N + 3) begin
                idle(1'b1);
                chk("rf_no_out", gi, out_valid, 0);
            end

            // Random traffic with random stalls.
            lat_chk = 1'b0;
            nacc    = 0;
            while (nacc < NRAND) begin
                drive($urandom_range(0, 9) < 8, W'($urandom), W'($urandom),
                      1'($urandom), 1'($urandom), $urandom_range(0, 9) < 7, t);
                if (t) nacc++;
            end
            repeat (N + 4) idle(1'b1);
            chk("final_drain", gi, exp_q.size(), 0);
            done_cnt++;
        end
    end

    initial begin
        for (int c = 0; c < 90000; c++) begin
            @(posedge clk);
            if (done_cnt == NCFG) break;
        end
        if (done_cnt != NCFG) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d configs done, want %0d", done_cnt, NCFG);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cla_pipe_adder.md
# cla_pipe_adder

Parametrised, pipelined carry-lookahead adder/subtractor with valid/ready handshaking and status flags. It generalises the team's fixed 4-bit combinational CLA to any width that is a multiple of the lookahead block size. One BLOCK-bit lookahead slice is evaluated per pipeline stage, giving a throughput of one operation per cycle. It sits between operand-producing logic and any consumer that can apply backpressure.

## Interface
- WIDTH, 16, operand/result width. Must be a multiple of BLOCK; any other value is an elaboration error.
- BLOCK, 4, bits per lookahead slice, legal range 1..8. NSTG = WIDTH/BLOCK pipeline stages.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in (add) or borrow-in (sub).
- sub  in  1  0 = add, 1 = subtract.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result this cycle.
- sum  out  WIDTH  result.
- cout  out  1  carry out of the MSB. In sub mode, 1 = no borrow.
- ovf  out  1  signed overflow.
- zero  out  1  sum == 0.

## Operation
- Accept: an input beat is accepted on a clock edge where in_valid && in_ready.
- Operand conditioning at accept:
  - beff = sub ? ~b : b.
  - c0 = sub ? ~cin : cin.
  - Results: add gives a+b+cin; sub gives a−b−cin.
- Stage k (0..NSTG−1) handles bits [k*BLOCK +: BLOCK]:
  - P = a^beff, G = a&beff.
  - All BLOCK internal carries come from flattened lookahead sum-of-products of P, G and the stage carry-in. No ripple inside a block.
  - Sum bit i = P[i] ^ c[i].
  - Block carry-out is registered and becomes the carry-in of stage k+1.
- Each stage register holds:
  - a valid bit;
  - the not-yet-consumed upper operand bits (a, beff);
  - the sum bits produced so far;
  - the running carry.
- The final stage registers the outputs:
  - sum;
  - cout = carry out of bit WIDTH−1;
  - ovf = carry into MSB XOR carry out of MSB;
  - zero = (sum == 0).
- Flow control:
  - Global enable en = !out_valid || out_ready.
  - in_ready = en. This is a combinational path from out_valid/out_ready; no other inputs feed it.
  - When en = 1, all stages advance together. Bubbles (valid = 0) propagate like data.
  - When en = 0, every stage register and all outputs hold.
- Results leave strictly in acceptance order. No beat is dropped or duplicated.

## Timing
- Reset values:
  - out_valid = 0, sum = 0, cout = 0, ovf = 0, zero = 0.
  - All stage valid and data registers = 0.
  - in_ready = 1 while rst is low after reset (out_valid = 0).
- Latency: a beat accepted at edge t produces out_valid = 1 after edge t+NSTG−1, i.e. visible NSTG cycles after acceptance with no stall. NSTG = 1 gives single-cycle latency.
- Throughput: one beat per cycle while out_ready = 1.
- Stall:
  - out_valid && !out_ready holds sum, cout, ovf and zero stable and forces in_ready = 0.
  - Release: the pipeline advances on the first edge where out_ready = 1.
- Simultaneous output pop and input push in the same cycle are legal and lossless.
- in_valid = 0 inserts a bubble. out_valid goes low NSTG cycles later unless stalled.
- Reset mid-operation: all in-flight beats are discarded and out_valid drops asynchronously. No discarded beat is ever emitted.
- Wrap-around: the sum is modulo 2^WIDTH; cout and ovf report the wrap.

## Test plan
Defaults are WIDTH=16, BLOCK=4 unless stated.
- Reset: assert rst for 2 cycles, then release. Required: out_valid=0, sum=0x0000, cout=0, ovf=0, zero=0, in_ready=1.
- Add boundaries:
  - a=0xFFFF, b=0x0001, cin=0, sub=0 → sum=0x0000, cout=1, zero=1, ovf=0, with out_valid exactly 4 cycles after accept.
  - a=0x7FFF, b=0x0001 → sum=0x8000, ovf=1, cout=0.
- Subtract:
  - a=0x0005, b=0x0007, sub=1, cin=0 → sum=0xFFFE, cout=0.
  - a=0x8000, b=0x0001, sub=1 → sum=0x7FFF, ovf=1, cout=1.
  - a=0x0005, b=0x0005, sub=1, cin=1 → sum=0xFFFF, cout=0.
- Streaming: 8 back-to-back beats (a=i, b=0x1000*i, i=0..7) with out_ready=1. Required: 8 consecutive out_valid cycles starting 4 cycles after the first accept, in order, each sum = a+b.
- Backpressure: fill the pipe, then hold out_ready=0 for 5 cycles. Required: in_ready=0 and the outputs stable throughout. On release, all beats emerge once, in order.
- Reset mid-flight and parameter sweep:
  - Assert rst asynchronously with 3 beats in flight → out_valid=0 immediately, and no result appears afterwards.
  - Repeat 10k random beats with random stalls at (WIDTH, BLOCK) = (16,4), (8,8), (32,4), (12,3), checking against a behavioural model.
